nios_system_sdram_keys: RTL and testbench

Avalon-MM slave input port for the robot's push-buttons and switches; it is the read-side counterpart of the LED output port on the same Nios II system bus. Each input bit is synchronised, debounced with a per-bit counter and edge-detected. Detected edges are latched in a sticky edge-capture register that software clears by writing 1s. A maskable level interrupt goes to the Nios II IRQ controller.

---
 rtl/nios_system_sdram_keys_if.sv | 25 ++
 rtl/nios_system_sdram_keys.sv | 139 +++++++++++++
 tb/tb_nios_system_sdram_keys.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios_system_sdram_keys_if.sv
// Avalon-MM slave bus bundle for the push-button/switch input port.
// The Nios II side acts as master; the key port is the slave.
interface nios_system_sdram_keys_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_sdram_keys.sv
// Push-button / switch input port for the robot's Nios II system.
// Each raw input bit is synchronised, debounced with its own counter and
// edge-detected; edges are held in a sticky write-1-to-clear register and
// a maskable level interrupt is raised towards the IRQ controller.
module nios_system_sdram_keys #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    nios_system_sdram_keys_if.slave avalon,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_level;
    logic [WIDTH-1:0] deb_level;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] clr_bits;
    logic             bus_write;
    logic [31:0]      rdata;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign bus_write  = avalon.chipselect && !avalon.write_n;

    // Synchroniser chain: stage 0 samples the asynchronous pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // accept[i] marks the cycle in which bit i's debounced level takes the
    // synchronised value; it can only fire while the two levels differ.
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign accept = sync_level ^ deb_level;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [CNT_W-1:0] cnt;

                // Count consecutive disagreeing cycles; any agreement restarts.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        cnt <= '0;
                    end else if (sync_level[i] == deb_level[i]) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                assign accept[i] = (sync_level[i] != deb_level[i]) && (cnt == CNT_LAST);
            end
        end
    endgenerate

    // Debounced level: flipping an accepted bit yields the synchronised value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_level <= '0;
        end else begin
            deb_level <= deb_level ^ accept;
        end
    end

    // Edge events are decided from the transition about to be accepted so the
    // capture register sets on the same edge the debounced level changes.
    always_comb begin
        edge_evt = '0;
        case (EDGE_TYPE)
            0:       edge_evt = accept & ~deb_level;
            1:       edge_evt = accept & deb_level;
            default: edge_evt = accept;
        endcase
    end

    assign clr_bits = (bus_write && avalon.address == 2'd3) ? avalon.writedata[WIDTH-1:0] : '0;

    // Interrupt mask register, written at word address 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (bus_write && avalon.address == 2'd2) begin
            irq_mask <= avalon.writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; a new edge beats a simultaneous clear of that bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= edge_evt | (edge_cap & ~clr_bits);
        end
    end

    assign irq = |(edge_cap & irq_mask);

    // Zero-wait-state read mux; upper bits and address 1 read as zero.
    always_comb begin
        rdata = '0;
        case (avalon.address)
            2'd0:    rdata[WIDTH-1:0] = deb_level;
            2'd2:    rdata[WIDTH-1:0] = irq_mask;
            2'd3:    rdata[WIDTH-1:0] = edge_cap;
            default: rdata = '0;
        endcase
    end

    assign avalon.readdata = rdata;

    // Write data bits above the port width carry no meaning here.
    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^avalon.writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_nios_system_sdram_keys.sv
// Scoreboard bench for the key input port. Three instances share the same
// pins and bus traffic and differ only in which edge direction they capture.
module tb_nios_system_sdram_keys;

    localparam int WIDTH = 4;
    localparam int DEB   = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_port;
    logic             irq_rise;
    logic             irq_fall;
    logic             irq_any;
    logic             chk_valid;
    int               checks;
    int               failures;
    exp_t             sb[$];
    exp_t             cur;
    logic [31:0]      act_rdata;
    logic             act_irq;

    nios_system_sdram_keys_if bus_rise ();
    nios_system_sdram_keys_if bus_fall ();
    nios_system_sdram_keys_if bus_any ();

    assign bus_fall.address    = bus_rise.address;
    assign bus_fall.chipselect = bus_rise.chipselect;
    assign bus_fall.write_n    = bus_rise.write_n;
    assign bus_fall.writedata  = bus_rise.writedata;
    assign bus_any.address     = bus_rise.address;
    assign bus_any.chipselect  = bus_rise.chipselect;
    assign bus_any.write_n     = bus_rise.write_n;
    assign bus_any.writedata   = bus_rise.writedata;

    nios_system_sdram_keys #(.WIDTH(WIDTH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset(reset), .avalon(bus_rise), .in_port(in_port), .irq(irq_rise)
    );

    nios_system_sdram_keys #(.WIDTH(WIDTH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset(reset), .avalon(bus_fall), .in_port(in_port), .irq(irq_fall)
    );

    nios_system_sdram_keys #(.WIDTH(WIDTH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset(reset), .avalon(bus_any), .in_port(in_port), .irq(irq_any)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: on each presented read, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (chk_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL scoreboard_empty: read presented with no expectation queued");
            end else begin
                cur = sb.pop_front();
                case (cur.sel)
                    1:       begin act_rdata = bus_fall.readdata; act_irq = irq_fall; end
                    2:       begin act_rdata = bus_any.readdata;  act_irq = irq_any;  end
                    default: begin act_rdata = bus_rise.readdata; act_irq = irq_rise; end
                endcase
                if (act_rdata !== cur.rdata || act_irq !== cur.irq) begin
                    failures++;
                    $display("[TB] FAIL %s: got readdata=%h irq=%b, expected readdata=%h irq=%b",
                             cur.name, act_rdata, act_irq, cur.rdata, cur.irq);
                end
            end
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus_rise.address    = addr;
        bus_rise.writedata  = data;
        bus_rise.chipselect = 1'b1;
        bus_rise.write_n    = 1'b0;
        step(1);
        bus_rise.chipselect = 1'b0;
        bus_rise.write_n    = 1'b1;
        bus_rise.writedata  = '0;
    endtask

    task automatic check_read(input string name, input int sel, input logic [1:0] addr,
                              input logic [31:0] exp_data, input logic exp_irq);
        exp_t e;
        e.name  = name;
        e.sel   = sel;
        e.rdata = exp_data;
        e.irq   = exp_irq;
        bus_rise.address    = addr;
        bus_rise.chipselect = 1'b1;
        bus_rise.write_n    = 1'b1;
        sb.push_back(e);
        chk_valid = 1'b1;
        step(1);
        chk_valid = 1'b0;
        bus_rise.chipselect = 1'b0;
    endtask

    initial begin
        checks              = 0;
        failures            = 0;
        chk_valid           = 1'b0;
        reset               = 1'b1;
        in_port             = '0;
        bus_rise.address    = '0;
        bus_rise.chipselect = 1'b0;
        bus_rise.write_n    = 1'b1;
        bus_rise.writedata  = '0;
        step(3);
        reset = 1'b0;

        // Reset state, then a clean rising edge on bit 0 accepted at edge 9.
        for (int a = 0; a < 4; a++) begin
            check_read($sformatf("reset_addr%0d", a), 0, 2'(a), 32'h0, 1'b0);
        end
        in_port = 4'b0001;
        step(9);
        check_read("data_before_edge9", 0, 2'd0, 32'h0, 1'b0);
        check_read("data_at_edge9", 0, 2'd0, 32'h1, 1'b0);
        check_read("ec_at_edge9_unmasked", 0, 2'd3, 32'h1, 1'b0);

        // Mask enables irq immediately; W1C clears it; addresses 0/1 ignore writes.
        bus_write(2'd2, 32'h1);
        check_read("mask_write_irq", 0, 2'd2, 32'h1, 1'b1);
        bus_write(2'd3, 32'h1);
        check_read("ec_clear_irq_low", 0, 2'd3, 32'h0, 1'b0);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        check_read("ignored_wr_data", 0, 2'd0, 32'h1, 1'b0);
        check_read("ignored_wr_addr1", 0, 2'd1, 32'h0, 1'b0);
        check_read("ignored_wr_mask", 0, 2'd2, 32'h1, 1'b0);
        check_read("ignored_wr_ec", 0, 2'd3, 32'h0, 1'b0);

        // Bit 1 bounces 5 high / 2 low, then holds; accepted 8 clocks after s settles.
        in_port = 4'b0011;
        step(5);
        in_port = 4'b0001;
        step(2);
        in_port = 4'b0011;
        step(9);
        check_read("bounce_not_yet", 0, 2'd0, 32'h1, 1'b0);
        check_read("bounce_accepted", 0, 2'd0, 32'h3, 1'b0);
        check_read("bounce_ec", 0, 2'd3, 32'h2, 1'b0);
        step(12);
        check_read("bounce_single_capture", 0, 2'd3, 32'h2, 1'b0);
        bus_write(2'd3, 32'h2);

        // Bit 2 rises then falls; each instance captures its own direction.
        in_port = 4'b0111;
        step(10);
        check_read("rise_ec_type0", 0, 2'd3, 32'h4, 1'b0);
        check_read("rise_ec_type1", 1, 2'd3, 32'h0, 1'b0);
        check_read("rise_ec_type2", 2, 2'd3, 32'h4, 1'b0);
        bus_write(2'd3, 32'h4);
        in_port = 4'b0011;
        step(12);
        check_read("fall_ec_type0", 0, 2'd3, 32'h0, 1'b0);
        check_read("fall_ec_type1", 1, 2'd3, 32'h4, 1'b0);
        check_read("fall_ec_type2", 2, 2'd3, 32'h4, 1'b0);
        bus_write(2'd3, 32'h4);

        // Re-arm ec[0], then clear all bits on the edge where d[3] rises.
        in_port = 4'b0010;
        step(12);
        in_port = 4'b0011;
        step(12);
        check_read("ec0_rearmed_irq", 0, 2'd3, 32'h1, 1'b1);
        in_port = 4'b1011;
        step(9);
        bus_write(2'd3, 32'hF);
        check_read("set_beats_clear", 0, 2'd3, 32'h8, 1'b0);
        check_read("data_bit3_high", 0, 2'd0, 32'hB, 1'b0);

        // Reset in the middle of a debounce count with the key held high.
        in_port = 4'b0000;
        step(12);
        bus_write(2'd3, 32'hF);
        check_read("pre_reset_ec_clear", 0, 2'd3, 32'h0, 1'b0);
        in_port = 4'b0001;
        step(7);
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            check_read($sformatf("midcount_reset_addr%0d", a), 0, 2'(a), 32'h0, 1'b0);
        end
        reset = 1'b0;
        step(9);
        check_read("post_reset_data_early", 0, 2'd0, 32'h0, 1'b0);
        check_read("post_reset_data_edge9", 0, 2'd0, 32'h1, 1'b0);
        check_read("post_reset_ec", 0, 2'd3, 32'h1, 1'b0);
        check_read("post_reset_mask", 0, 2'd2, 32'h0, 1'b0);

        step(2);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_leftover: %0d expectations never compared, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
